shared_counter_arbiter: RTL and testbench
=========================================

SHARED_COUNTER_ARBITER -- requirements
Module: shared_counter_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and delta width in bits.
REQ-002 The block SHALL have parameter MERGE, default 0; 0 serializes simultaneous updates, 1 combines them in one cycle.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req_a  input  1  requester A update request.
REQ-006 The block SHALL have port delta_a  input  WIDTH  unsigned increment from requester A.
REQ-007 The block SHALL have port ack_a  output  1  one-cycle pulse: A's update applied.
REQ-008 The block SHALL have port req_b  input  1  requester B update request.
REQ-009 The block SHALL have port delta_b  input  WIDTH  unsigned increment from requester B.
REQ-010 The block SHALL have port ack_b  output  1  one-cycle pulse: B's update applied.
REQ-011 The block SHALL have port count  output  WIDTH  registered shared counter value.
REQ-012 The block SHALL have port upd_valid  output  1  one-cycle pulse: count changed this edge.
REQ-013 The block SHALL have port upd_src  output  2  source of last update: 01 A, 10 B, 11 both, 00 none.
REQ-014 The block SHALL have port wrap  output  1  one-cycle pulse: last update overflowed 2^WIDTH.
REQ-015 The block SHALL have port prio  output  1  round-robin pointer: 0 A preferred, 1 B preferred.

Function
REQ-016 count SHALL be the only storage for the shared value; it is written from exactly one sequential process, so simultaneous requests never race.
REQ-017 A requester SHALL be eligible at an edge when its req is high and its own ack is low; a req held high during its ack cycle is ignored.
REQ-018 The block SHALL apply at most one update per requester per two cycles, even with req held high continuously.
REQ-019 Latency: a request sampled at edge k SHALL produce ack, count, upd_valid, upd_src and wrap after edge k, all valid in cycle k+1.
REQ-020 When only one requester is eligible, the block SHALL set count <= count + delta, assert that requester's ack, set upd_src to it, and point prio at the other requester.
REQ-021 With MERGE=0 and both requesters eligible, the block SHALL grant the requester named by prio, then point prio at the other one; the loser keeps its request and is granted at the next edge.
REQ-022 With MERGE=1 and both requesters eligible, the block SHALL set count <= count + delta_a + delta_b, assert both acks, set upd_src=11, and leave prio unchanged.
REQ-023 The block SHALL compute sums at WIDTH+2 bits, truncate count mod 2^WIDTH, and pulse wrap when the full sum is >= 2^WIDTH (a flag, not a wrap count).
REQ-024 A delta of 0 SHALL still count as an update: ack, upd_valid and upd_src are asserted and count is unchanged.
REQ-025 When no requester is eligible, count, prio and upd_src SHALL hold, and ack_a, ack_b, upd_valid and wrap SHALL be 0.
REQ-026 Deltas SHALL be sampled on the same edge as the grant and need not stay stable afterward.

Reset
REQ-027 When rst_n is low, the block SHALL immediately force count=0, ack_a=0, ack_b=0, upd_valid=0, upd_src=00, wrap=0 and prio=0, without waiting for clk.
REQ-028 Requests pending when reset is asserted mid-operation SHALL be dropped; no ack is issued for them.
REQ-029 At the first rising edge after rst_n goes high, the block SHALL arbitrate normally with A preferred.

Verification
REQ-030 Single request: reset, then req_a=1 with delta_a=1 for one cycle -> next cycle ack_a=1, count=1, upd_src=01, prio=1, upd_valid=1.
REQ-031 Contention, MERGE=0: req_a and req_b held high, delta_a=1, delta_b=2, from count=0 -> count sequence 1,3,4,6,7,..., acks alternate A,B,A,B, and ack_a and ack_b are never high in the same cycle.
REQ-032 Merge: MERGE=1, both requests in the same cycle, delta_a=1, delta_b=2, from count=0 -> count=3, ack_a=ack_b=1, upd_src=11, prio unchanged.
REQ-033 Wrap: count=14 (WIDTH=4), req_a with delta_a=3 -> count=1 and wrap=1 for one cycle.
REQ-034 Merge wrap: MERGE=1, count=15, delta_a=15, delta_b=15 -> count=13 and wrap=1.
REQ-035 Mid-operation reset: req_a and req_b held high and rst_n pulsed low between edges -> all outputs go to 0 at once; no ack until the first edge after release, and that ack is ack_a.

Source files
------------

// File: rtl/shared_counter_arbiter.sv
// Shared counter updated by two requesters through a round-robin arbiter.
// With MERGE=1, simultaneous updates are applied together in a single cycle.
module shared_counter_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MERGE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] delta_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] delta_b,
  output logic             ack_b,
  output logic [WIDTH-1:0] count,
  output logic             upd_valid,
  output logic [1:0]       upd_src,
  output logic             wrap,
  output logic             prio
);

  logic             elig_a, elig_b;
  logic             grant_a, grant_b;
  logic [WIDTH+1:0] add_a, add_b, sum;

  always_comb begin
    // A requester whose ack is currently high sits out this edge.
    elig_a  = req_a & ~ack_a;
    elig_b  = req_b & ~ack_b;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (elig_a && elig_b) begin
      if (MERGE != 0) begin
        grant_a = 1'b1;
        grant_b = 1'b1;
      end else if (prio) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = elig_a;
      grant_b = elig_b;
    end
    add_a = grant_a ? {2'b00, delta_a} : '0;
    add_b = grant_b ? {2'b00, delta_b} : '0;
    sum   = {2'b00, count} + add_a + add_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      upd_valid <= 1'b0;
      upd_src   <= 2'b00;
      wrap      <= 1'b0;
      prio      <= 1'b0;
    end else begin
      ack_a     <= grant_a;
      ack_b     <= grant_b;
      upd_valid <= grant_a | grant_b;
      wrap      <= (grant_a | grant_b) && (sum[WIDTH+1:WIDTH] != 2'b00);
      if (grant_a || grant_b) begin
        count   <= sum[WIDTH-1:0];
        upd_src <= {grant_b, grant_a};
        // A single grant hands preference to the other side; a merged grant leaves it.
        if (!(grant_a && grant_b)) begin
          prio <= grant_a;
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Directed bench: vector table on the serializing instance, hand sequences
// for merge, wrap and mid-operation reset.
module tb_shared_counter_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a0, req_b0, req_a1, req_b1;
  logic [3:0] delta_a0, delta_b0, delta_a1, delta_b1;
  logic       ack_a0, ack_b0, valid0, wrap0, prio0;
  logic       ack_a1, ack_b1, valid1, wrap1, prio1;
  logic [3:0] count0, count1;
  logic [1:0] src0, src1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  shared_counter_arbiter #(.WIDTH(4), .MERGE(0)) u_ser (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a0), .delta_a(delta_a0), .ack_a(ack_a0),
    .req_b(req_b0), .delta_b(delta_b0), .ack_b(ack_b0),
    .count(count0), .upd_valid(valid0), .upd_src(src0), .wrap(wrap0), .prio(prio0)
  );

  shared_counter_arbiter #(.WIDTH(4), .MERGE(1)) u_mrg (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a1), .delta_a(delta_a1), .ack_a(ack_a1),
    .req_b(req_b1), .delta_b(delta_b1), .ack_b(ack_b1),
    .count(count1), .upd_valid(valid1), .upd_src(src1), .wrap(wrap1), .prio(prio1)
  );

  typedef struct packed {
    logic       ra;
    logic [3:0] da;
    logic       rb;
    logic [3:0] db;
    logic [3:0] ec;
    logic       eaa;
    logic       eab;
    logic       ev;
    logic [1:0] es;
    logic       ew;
    logic       ep;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ser(input string tag, input logic [3:0] ec, input logic eaa, input logic eab,
                         input logic ev, input logic [1:0] es, input logic ew, input logic ep);
    chk({tag, " count"}, 32'(count0), 32'(ec));
    chk({tag, " ack_a"}, 32'(ack_a0), 32'(eaa));
    chk({tag, " ack_b"}, 32'(ack_b0), 32'(eab));
    chk({tag, " upd_valid"}, 32'(valid0), 32'(ev));
    chk({tag, " upd_src"}, 32'(src0), 32'(es));
    chk({tag, " wrap"}, 32'(wrap0), 32'(ew));
    chk({tag, " prio"}, 32'(prio0), 32'(ep));
  endtask

  task automatic chk_mrg(input string tag, input logic [3:0] ec, input logic eaa, input logic eab,
                         input logic ev, input logic [1:0] es, input logic ew, input logic ep);
    chk({tag, " count"}, 32'(count1), 32'(ec));
    chk({tag, " ack_a"}, 32'(ack_a1), 32'(eaa));
    chk({tag, " ack_b"}, 32'(ack_b1), 32'(eab));
    chk({tag, " upd_valid"}, 32'(valid1), 32'(ev));
    chk({tag, " upd_src"}, 32'(src1), 32'(es));
    chk({tag, " wrap"}, 32'(wrap1), 32'(ew));
    chk({tag, " prio"}, 32'(prio1), 32'(ep));
  endtask

  task automatic drive_mrg(input logic ra, input logic [3:0] da, input logic rb,
                           input logic [3:0] db);
    req_a1 = ra; delta_a1 = da; req_b1 = rb; delta_b1 = db;
  endtask

  initial begin
    //            ra    da     rb    db     count  aa    ab    v     src    w     prio
    vecs[0]  = '{1'b0, 4'd0, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd1, 1'b0, 4'd0, 4'd1,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 4'd0, 1'b0, 4'd0, 4'd1,  1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd0, 4'd1,  1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd1, 1'b1, 4'd2, 4'd2,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 4'd1, 1'b1, 4'd2, 4'd4,  1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd1, 1'b1, 4'd2, 4'd5,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'd1, 1'b1, 4'd2, 4'd7,  1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd0, 1'b0, 4'd0, 4'd7,  1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd7, 1'b0, 4'd0, 4'd14, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 4'd0, 4'd14, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 4'd3, 1'b0, 4'd0, 4'd1,  1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 4'd0, 1'b0, 4'd0, 4'd1,  1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 4'd2, 1'b1, 4'd4, 4'd5,  1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'd2, 1'b0, 4'd0, 4'd7,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 4'd2, 1'b0, 4'd0, 4'd7,  1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 4'd2, 1'b0, 4'd0, 4'd9,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};

    rst_n = 1'b0;
    req_a0 = 1'b0; delta_a0 = 4'd0; req_b0 = 1'b0; delta_b0 = 4'd0;
    drive_mrg(1'b0, 4'd0, 1'b0, 4'd0);
    #3;
    chk_ser("reset ser", 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk_mrg("reset mrg", 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      req_a0 = vecs[i].ra; delta_a0 = vecs[i].da;
      req_b0 = vecs[i].rb; delta_b0 = vecs[i].db;
      step();
      chk_ser($sformatf("v%0d", i), vecs[i].ec, vecs[i].eaa, vecs[i].eab, vecs[i].ev,
              vecs[i].es, vecs[i].ew, vecs[i].ep);
    end
    req_a0 = 1'b0; req_b0 = 1'b0;

    // Merge instance: combined update, then wrap from 15 with 15+15.
    drive_mrg(1'b1, 4'd1, 1'b1, 4'd2); step();
    chk_mrg("merge 1+2", 4'd3, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    drive_mrg(1'b0, 4'd0, 1'b0, 4'd0); step();
    chk_mrg("merge idle", 4'd3, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    drive_mrg(1'b1, 4'd6, 1'b1, 4'd6); step();
    chk_mrg("merge to 15", 4'd15, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    drive_mrg(1'b0, 4'd0, 1'b0, 4'd0); step();
    drive_mrg(1'b1, 4'd15, 1'b1, 4'd15); step();
    chk_mrg("merge wrap", 4'd13, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    drive_mrg(1'b0, 4'd0, 1'b0, 4'd0); step();
    chk_mrg("merge wrap clear", 4'd13, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    drive_mrg(1'b1, 4'd1, 1'b0, 4'd0); step();
    chk_mrg("merge single a", 4'd14, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
    drive_mrg(1'b0, 4'd0, 1'b0, 4'd0); step();
    drive_mrg(1'b1, 4'd1, 1'b1, 4'd1); step();
    chk_mrg("merge prio kept", 4'd0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    drive_mrg(1'b0, 4'd0, 1'b0, 4'd0);

    // Mid-operation reset with both requests held.
    req_a0 = 1'b1; delta_a0 = 4'd1; req_b0 = 1'b1; delta_b0 = 4'd2;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_ser("async reset", 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_ser("held reset", 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_ser("post reset", 4'd1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
    step();
    chk_ser("post reset b", 4'd3, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
